// File: rtl/adxl_spi_reader_if.sv
// SPI pins and sample outputs of the accelerometer reader.
//   master : reader side (drives SPI pins and sample outputs, reads miso)
//   slave  : sensor/consumer side (drives miso, observes everything else)
interface adxl_spi_reader_if;
    logic        sclk;
    logic        cs_n;
    logic        mosi;
    logic        miso;
    logic [15:0] x_out;
    logic [15:0] y_out;
    logic [15:0] z_out;
    logic        sample_valid;
    logic        init_done;

    modport master (
        output sclk, cs_n, mosi, x_out, y_out, z_out, sample_valid, init_done,
        input  miso
    );

    modport slave (
        input  sclk, cs_n, mosi, x_out, y_out, z_out, sample_valid, init_done,
        output miso
    );
endinterface

// File: rtl/adxl_spi_reader.sv
// SPI mode-3 master that configures an ADXL345-style accelerometer and
// periodically burst-reads X/Y/Z, presenting signed 16-bit samples.
//   clk   : system clock
//   reset : synchronous active-low reset
//   en    : high allows periodic reads
//   bus   : SPI pins (sclk, cs_n, mosi, miso) and sample outputs
//           (x_out, y_out, z_out, sample_valid, init_done)
module adxl_spi_reader #(
    parameter int unsigned CLK_DIV       = 25,
    parameter int unsigned SAMPLE_PERIOD = 500000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    adxl_spi_reader_if.master bus
);

    localparam int unsigned DIV_W  = $clog2(2 * CLK_DIV);
    localparam int unsigned CNT_W  = $clog2(SAMPLE_PERIOD);
    localparam int unsigned HALF_W = 7;
    localparam int unsigned TX_W   = 56;
    localparam int unsigned RX_W   = 48;

    localparam logic [DIV_W-1:0]  DIV_HALF_END = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_GAP_END  = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [HALF_W-1:0] CFG_END      = HALF_W'(2 * 16);
    localparam logic [HALF_W-1:0] READ_END     = HALF_W'(2 * 56);

    localparam logic [15:0] CFG_POWER_WORD = 16'h2D08;
    localparam logic [15:0] CFG_FMT_WORD   = 16'h310B;
    localparam logic [7:0]  READ_CMD       = 8'hF2;

    typedef enum logic [2:0] {
        ST_CFG_POWER,
        ST_CFG_FMT,
        ST_WAIT,
        ST_READ,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [HALF_W-1:0] half_q, half_d;
    logic [TX_W-1:0]   tx_q, tx_d;
    logic [RX_W-1:0]   rx_q, rx_d;
    logic              cs_n_q, cs_n_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic [15:0]       x_q, x_d, y_q, y_d, z_q, z_d;
    logic              valid_q, valid_d;
    logic              init_q, init_d;

    logic              tick;
    logic              in_frame_state;
    logic [HALF_W-1:0] half_last;
    logic [TX_W-1:0]   tx_load;

    assign tick = (cnt_q == CNT_LAST);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_CFG_POWER;
            cnt_q   <= '0;
            div_q   <= '0;
            half_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b1;
            mosi_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            valid_q <= 1'b0;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            half_q  <= half_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            valid_q <= valid_d;
            init_q  <= init_d;
        end
    end

    // Next-state: frame sequencing, SPI edge generation and sample capture
    always_comb begin
        state_d = state_q;
        cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);
        div_d   = div_q;
        half_d  = half_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        valid_d = 1'b0;
        init_d  = init_q;

        in_frame_state = (state_q == ST_CFG_POWER) || (state_q == ST_CFG_FMT) ||
                         (state_q == ST_READ);
        half_last      = (state_q == ST_READ) ? READ_END : CFG_END;

        case (state_q)
            ST_CFG_POWER: tx_load = {CFG_POWER_WORD, 40'h0};
            ST_CFG_FMT:   tx_load = {CFG_FMT_WORD, 40'h0};
            default:      tx_load = {READ_CMD, 48'h0};
        endcase

        if (cs_n_q) begin
            // While deselected, div counts the inter-frame gap and saturates,
            // so a READ entered from a long WAIT starts on the next cycle.
            if (div_q != DIV_GAP_END) begin
                div_d = div_q + DIV_W'(1);
            end
            if (in_frame_state && (div_q == DIV_GAP_END)) begin
                cs_n_d = 1'b0;
                div_d  = '0;
                half_d = '0;
                tx_d   = tx_load;
            end
        end else if (div_q == DIV_HALF_END) begin
            div_d  = '0;
            half_d = half_q + HALF_W'(1);
            if (half_q == half_last) begin
                cs_n_d = 1'b1;
                case (state_q)
                    ST_CFG_POWER: state_d = ST_CFG_FMT;
                    ST_CFG_FMT: begin
                        state_d = ST_WAIT;
                        init_d  = 1'b1;
                    end
                    default: begin
                        // rx holds X0,X1,Y0,Y1,Z0,Z1 from MSB down
                        state_d = ST_DONE;
                        x_d     = {rx_q[39:32], rx_q[47:40]};
                        y_d     = {rx_q[23:16], rx_q[31:24]};
                        z_d     = {rx_q[7:0],   rx_q[15:8]};
                        valid_d = 1'b1;
                    end
                endcase
            end else if (!half_q[0]) begin
                sclk_d = 1'b0;
                mosi_d = tx_q[TX_W-1];
                tx_d   = {tx_q[TX_W-2:0], 1'b0};
            end else begin
                sclk_d = 1'b1;
                rx_d   = {rx_q[RX_W-2:0], bus.miso};
            end
        end else begin
            div_d = div_q + DIV_W'(1);
        end

        case (state_q)
            ST_WAIT: if (tick && en) state_d = ST_READ;
            ST_DONE: state_d = ST_WAIT;
            default: ;
        endcase
    end

    assign bus.sclk         = sclk_q;
    assign bus.cs_n         = cs_n_q;
    assign bus.mosi         = mosi_q;
    assign bus.x_out        = x_q;
    assign bus.y_out        = y_q;
    assign bus.z_out        = z_q;
    assign bus.sample_valid = valid_q;
    assign bus.init_done    = init_q;

endmodule

// File: tb/tb_adxl_spi_reader.sv
// Bench for adxl_spi_reader: a sensor model answers SPI frames and records
// them; scenario tasks compare the DUT against arithmetic expectations.
module tb_adxl_spi_reader;

    localparam int C        = 2;
    localparam int SP       = 400;
    localparam int READ_LAT = 113 * C;

    typedef struct {
        logic [63:0] bits;
        int          nfall;
        int          nrise;
        logic        init_end;
    } frame_t;

    typedef struct {
        int          cyc;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
    } sample_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic en    = 1'b0;

    adxl_spi_reader_if bus();

    adxl_spi_reader #(.CLK_DIV(C), .SAMPLE_PERIOD(SP)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   cyc      = 0;
    logic rst_edge = 1'b0;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_edge <= reset;
    end

    // Sensor model / bus monitor state
    frame_t      frames[$];
    sample_t     sv_q[$];
    sample_t     exp_q[$];
    logic [15:0] sx = 16'hFE0C, sy = 16'h0032, sz = 16'h0100;
    logic [55:0] resp = '0;
    sample_t     snap;
    logic [63:0] cur_bits = '0;
    int          cur_fall = 0, cur_rise = 0;
    logic        in_frame = 1'b0;
    int          last_evt = 0, last_rise = -100000;
    int          phase_err = 0, gap_err = 0, mosi_err = 0, sv_width_err = 0;
    logic        prev_cs = 1'b1, prev_sclk = 1'b1, prev_mosi = 1'b0, prev_sv = 1'b0;

    always @(negedge clk) begin
        frame_t  f;
        sample_t ev;
        if (bus.cs_n === 1'b1) bus.miso = 1'b0;
        if (rst_edge === 1'b1) begin
            if (prev_cs === 1'b1 && bus.cs_n === 1'b0) begin
                if (cyc - last_rise < 2 * C) gap_err++;
                in_frame = 1'b1;
                cur_bits = '0;
                cur_fall = 0;
                cur_rise = 0;
                last_evt = cyc;
                resp = {8'($urandom), sx[7:0], sx[15:8], sy[7:0], sy[15:8], sz[7:0], sz[15:8]};
                snap.x = sx; snap.y = sy; snap.z = sz; snap.cyc = cyc;
            end else if (in_frame && bus.cs_n === 1'b0 && bus.sclk !== prev_sclk) begin
                if (cyc - last_evt != C) phase_err++;
                last_evt = cyc;
                if (bus.sclk === 1'b0) begin
                    cur_bits = {cur_bits[62:0], bus.mosi};
                    if (cur_fall < 56) bus.miso = resp[55 - cur_fall];
                    cur_fall++;
                end else begin
                    cur_rise++;
                end
            end else if (in_frame && bus.cs_n === 1'b1) begin
                if (cyc - last_evt != C) phase_err++;
                f.bits = cur_bits; f.nfall = cur_fall; f.nrise = cur_rise;
                f.init_end = bus.init_done;
                frames.push_back(f);
                last_rise = cyc;
                in_frame  = 1'b0;
                if (cur_fall == 56 && cur_bits[55:48] == 8'hF2) begin
                    exp_q.push_back(snap);
                    sx = sx + 16'd50;
                    sy = 16'($urandom);
                    sz = 16'($urandom);
                end
            end
            if (prev_sclk === 1'b1 && bus.sclk === 1'b1 && bus.mosi !== prev_mosi) mosi_err++;
            if (bus.sample_valid === 1'b1) begin
                if (prev_sv === 1'b1) sv_width_err++;
                ev.cyc = cyc; ev.x = bus.x_out; ev.y = bus.y_out; ev.z = bus.z_out;
                sv_q.push_back(ev);
            end
        end else if (in_frame && bus.cs_n === 1'b1) begin
            in_frame  = 1'b0;
            last_rise = cyc;
        end
        prev_cs   = bus.cs_n;
        prev_sclk = bus.sclk;
        prev_mosi = bus.mosi;
        prev_sv   = bus.sample_valid;
    end

    int n_cmp = 0, n_fail = 0;
    int rel_cyc = 0;
    int sv_rd = 0, exp_rd = 0;
    int tick_k = 1;
    logic [15:0] prev_x = '0;
    int prev_cyc = 0;

    task automatic test_reset();
        reset = 1'b0;
        en    = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk); #1;
        n_cmp++; if (bus.cs_n !== 1'b1) begin n_fail++; $display("FAIL reset_cs_n: got %b want 1", bus.cs_n); end
        n_cmp++; if (bus.sclk !== 1'b1) begin n_fail++; $display("FAIL reset_sclk: got %b want 1", bus.sclk); end
        n_cmp++; if (bus.mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi: got %b want 0", bus.mosi); end
        n_cmp++; if (bus.x_out !== 16'h0) begin n_fail++; $display("FAIL reset_x: got %h want 0", bus.x_out); end
        n_cmp++; if (bus.y_out !== 16'h0) begin n_fail++; $display("FAIL reset_y: got %h want 0", bus.y_out); end
        n_cmp++; if (bus.z_out !== 16'h0) begin n_fail++; $display("FAIL reset_z: got %h want 0", bus.z_out); end
        n_cmp++; if (bus.sample_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.sample_valid); end
        n_cmp++; if (bus.init_done !== 1'b0) begin n_fail++; $display("FAIL reset_init: got %b want 0", bus.init_done); end
    endtask

    task automatic test_config();
        int g = 0;
        int base = frames.size();
        @(posedge clk); #1;
        reset   = 1'b1;
        rel_cyc = cyc;
        while (frames.size() < base + 2 && g < 400) begin @(negedge clk); #1; g++; end
        n_cmp++;
        if (frames.size() < base + 2) begin
            n_fail++; $display("FAIL cfg_frames: got %0d want 2", frames.size() - base);
            return;
        end
        n_cmp++; if (frames[base].bits[15:0] !== 16'h2D08) begin n_fail++; $display("FAIL cfg_power_word: got %h want 2d08", frames[base].bits[15:0]); end
        n_cmp++; if (frames[base].nfall !== 16) begin n_fail++; $display("FAIL cfg_power_falls: got %0d want 16", frames[base].nfall); end
        n_cmp++; if (frames[base].init_end !== 1'b0) begin n_fail++; $display("FAIL cfg_power_init: got %b want 0", frames[base].init_end); end
        n_cmp++; if (frames[base+1].bits[15:0] !== 16'h310B) begin n_fail++; $display("FAIL cfg_fmt_word: got %h want 310b", frames[base+1].bits[15:0]); end
        n_cmp++; if (frames[base+1].nfall !== 16) begin n_fail++; $display("FAIL cfg_fmt_falls: got %0d want 16", frames[base+1].nfall); end
        n_cmp++; if (frames[base+1].nrise !== 16) begin n_fail++; $display("FAIL cfg_fmt_rises: got %0d want 16", frames[base+1].nrise); end
        n_cmp++; if (frames[base+1].init_end !== 1'b1) begin n_fail++; $display("FAIL cfg_fmt_init: got %b want 1", frames[base+1].init_end); end
    endtask

    task automatic test_read();
        int g = 0;
        int fbase = frames.size();
        sample_t ev, ex;
        while (sv_q.size() <= sv_rd && g < 2 * SP) begin @(negedge clk); #1; g++; end
        n_cmp++;
        if (sv_q.size() <= sv_rd) begin n_fail++; $display("FAIL read_timeout: no sample_valid"); return; end
        ev = sv_q[sv_rd]; sv_rd++;
        ex = exp_q[exp_rd]; exp_rd++;
        n_cmp++; if (ev.x !== 16'hFE0C) begin n_fail++; $display("FAIL read_x: got %h want fe0c", ev.x); end
        n_cmp++; if (ev.y !== 16'h0032) begin n_fail++; $display("FAIL read_y: got %h want 0032", ev.y); end
        n_cmp++; if (ev.z !== 16'h0100) begin n_fail++; $display("FAIL read_z: got %h want 0100", ev.z); end
        n_cmp++; if (ev.x !== ex.x) begin n_fail++; $display("FAIL read_x_model: got %h want %h", ev.x, ex.x); end
        n_cmp++; if (ev.cyc !== rel_cyc + SP + 1 + READ_LAT) begin n_fail++; $display("FAIL read_latency: got %0d want %0d", ev.cyc, rel_cyc + SP + 1 + READ_LAT); end
        n_cmp++;
        if (frames.size() != fbase + 1) begin
            n_fail++; $display("FAIL read_frame_count: got %0d want 1", frames.size() - fbase);
        end else begin
            n_cmp++; if (frames[fbase].bits[55:48] !== 8'hF2) begin n_fail++; $display("FAIL read_cmd: got %h want f2", frames[fbase].bits[55:48]); end
            n_cmp++; if (frames[fbase].bits[47:0] !== 48'h0) begin n_fail++; $display("FAIL read_mosi_data: got %h want 0", frames[fbase].bits[47:0]); end
            n_cmp++; if (frames[fbase].nrise !== 56) begin n_fail++; $display("FAIL read_rises: got %0d want 56", frames[fbase].nrise); end
        end
        @(negedge clk); #1;
        n_cmp++; if (bus.sample_valid !== 1'b0) begin n_fail++; $display("FAIL read_valid_width: got %b want 0", bus.sample_valid); end
        prev_x   = ev.x;
        prev_cyc = ev.cyc;
        tick_k   = 2;
    endtask

    task automatic test_free_run();
        for (int k = 0; k < 5; k++) begin
            int g = 0;
            sample_t ev, ex;
            logic [15:0] dx;
            while (sv_q.size() <= sv_rd && g < SP + 50) begin @(negedge clk); #1; g++; end
            n_cmp++;
            if (sv_q.size() <= sv_rd) begin n_fail++; $display("FAIL run_timeout: pulse %0d missing", k); return; end
            ev = sv_q[sv_rd]; sv_rd++;
            ex = exp_q[exp_rd]; exp_rd++;
            dx = ev.x - prev_x;
            n_cmp++; if (dx !== 16'h0032) begin n_fail++; $display("FAIL run_x_step: got %h want 0032", dx); end
            n_cmp++; if (ev.y !== ex.y) begin n_fail++; $display("FAIL run_y: got %h want %h", ev.y, ex.y); end
            n_cmp++; if (ev.z !== ex.z) begin n_fail++; $display("FAIL run_z: got %h want %h", ev.z, ex.z); end
            n_cmp++; if (ev.cyc - prev_cyc !== SP) begin n_fail++; $display("FAIL run_spacing: got %0d want %0d", ev.cyc - prev_cyc, SP); end
            n_cmp++; if (ev.cyc !== rel_cyc + tick_k * SP + 1 + READ_LAT) begin n_fail++; $display("FAIL run_time: got %0d want %0d", ev.cyc, rel_cyc + tick_k * SP + 1 + READ_LAT); end
            prev_x   = ev.x;
            prev_cyc = ev.cyc;
            tick_k++;
        end
    endtask

    task automatic test_enable();
        int g, base, r, m, target;
        sample_t ev, ex;
        @(posedge clk); #1;
        en     = 1'b0;
        base   = frames.size();
        target = rel_cyc + (tick_k + 2) * SP - 1 + int'($urandom_range(1, SP - 2));
        while (cyc < target) @(posedge clk);
        #1;
        n_cmp++; if (frames.size() !== base) begin n_fail++; $display("FAIL en_low_frames: got %0d want 0", frames.size() - base); end
        n_cmp++; if (sv_q.size() !== sv_rd) begin n_fail++; $display("FAIL en_low_valid: got %0d want 0", sv_q.size() - sv_rd); end
        n_cmp++; if (bus.cs_n !== 1'b1) begin n_fail++; $display("FAIL en_low_cs_n: got %b want 1", bus.cs_n); end
        en = 1'b1;
        r  = cyc;
        m  = (r - rel_cyc + SP) / SP;
        g  = 0;
        while (!in_frame && g < SP + 10) begin @(posedge clk); #1; g++; end
        repeat ($urandom_range(5, 200)) @(posedge clk);
        #1;
        en = 1'b0;
        g  = 0;
        while (sv_q.size() <= sv_rd && g < SP + 300) begin @(negedge clk); #1; g++; end
        n_cmp++;
        if (sv_q.size() <= sv_rd) begin n_fail++; $display("FAIL en_raise_timeout: no sample_valid"); return; end
        ev = sv_q[sv_rd]; sv_rd++;
        ex = exp_q[exp_rd]; exp_rd++;
        n_cmp++; if (ev.cyc !== rel_cyc + m * SP + 1 + READ_LAT) begin n_fail++; $display("FAIL en_raise_time: got %0d want %0d", ev.cyc, rel_cyc + m * SP + 1 + READ_LAT); end
        n_cmp++; if (ev.x !== ex.x) begin n_fail++; $display("FAIL en_drop_x: got %h want %h", ev.x, ex.x); end
        base = frames.size();
        repeat (2 * SP) @(posedge clk);
        #1;
        n_cmp++; if (frames.size() !== base) begin n_fail++; $display("FAIL en_drop_frames: got %0d want 0", frames.size() - base); end
        n_cmp++; if (sv_q.size() !== sv_rd) begin n_fail++; $display("FAIL en_drop_valid: got %0d want 0", sv_q.size() - sv_rd); end
    endtask

    task automatic test_reset_mid_frame();
        int g = 0;
        int base;
        sample_t ev, ex;
        @(posedge clk); #1;
        en = 1'b1;
        while (!(in_frame && cur_fall >= 21) && g < 3 * SP) begin @(posedge clk); #1; g++; end
        n_cmp++;
        if (!(in_frame && cur_fall >= 21)) begin n_fail++; $display("FAIL mid_reset_timeout: no read frame"); return; end
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk); #1;
        n_cmp++; if (bus.cs_n !== 1'b1) begin n_fail++; $display("FAIL mid_reset_cs_n: got %b want 1", bus.cs_n); end
        n_cmp++; if (bus.sclk !== 1'b1) begin n_fail++; $display("FAIL mid_reset_sclk: got %b want 1", bus.sclk); end
        n_cmp++; if ({bus.x_out, bus.y_out, bus.z_out} !== 48'h0) begin n_fail++; $display("FAIL mid_reset_xyz: got %h want 0", {bus.x_out, bus.y_out, bus.z_out}); end
        n_cmp++; if (bus.init_done !== 1'b0) begin n_fail++; $display("FAIL mid_reset_init: got %b want 0", bus.init_done); end
        repeat (3) @(posedge clk);
        base = frames.size();
        #1;
        reset   = 1'b1;
        rel_cyc = cyc;
        g = 0;
        while (frames.size() < base + 1 && g < 200) begin @(negedge clk); #1; g++; end
        n_cmp++;
        if (frames.size() < base + 1) begin n_fail++; $display("FAIL mid_reset_restart: no frame"); return; end
        n_cmp++; if (frames[base].bits[15:0] !== 16'h2D08) begin n_fail++; $display("FAIL mid_reset_first_word: got %h want 2d08", frames[base].bits[15:0]); end
        n_cmp++; if (frames[base].nfall !== 16) begin n_fail++; $display("FAIL mid_reset_first_falls: got %0d want 16", frames[base].nfall); end
        g = 0;
        while (sv_q.size() <= sv_rd && g < 2 * SP) begin @(negedge clk); #1; g++; end
        n_cmp++;
        if (sv_q.size() <= sv_rd) begin n_fail++; $display("FAIL mid_reset_sample_timeout: no sample_valid"); return; end
        ev = sv_q[sv_rd]; sv_rd++;
        ex = exp_q[exp_rd]; exp_rd++;
        n_cmp++; if (ev.cyc !== rel_cyc + SP + 1 + READ_LAT) begin n_fail++; $display("FAIL mid_reset_latency: got %0d want %0d", ev.cyc, rel_cyc + SP + 1 + READ_LAT); end
        n_cmp++; if ({ev.x, ev.y, ev.z} !== {ex.x, ex.y, ex.z}) begin n_fail++; $display("FAIL mid_reset_sample: got %h want %h", {ev.x, ev.y, ev.z}, {ex.x, ex.y, ex.z}); end
    endtask

    task automatic test_edge_spacing();
        n_cmp++; if (phase_err !== 0) begin n_fail++; $display("FAIL edge_phase: got %0d bad phases want 0", phase_err); end
        n_cmp++; if (gap_err !== 0) begin n_fail++; $display("FAIL edge_cs_gap: got %0d short gaps want 0", gap_err); end
        n_cmp++; if (mosi_err !== 0) begin n_fail++; $display("FAIL edge_mosi_high: got %0d changes want 0", mosi_err); end
        n_cmp++; if (sv_width_err !== 0) begin n_fail++; $display("FAIL edge_valid_width: got %0d long pulses want 0", sv_width_err); end
    endtask

    initial begin
        test_reset();
        test_config();
        test_read();
        test_free_run();
        test_enable();
        test_reset_mid_frame();
        test_edge_spacing();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/adxl_spi_reader.md
Name: adxl_spi_reader

Overview:
- SPI master that configures an ADXL345-style 3-axis accelerometer and periodically burst-reads its six data registers.
- Delivers signed 16-bit X/Y/Z samples with a one-cycle valid strobe.
- It is the sample producer feeding the smoothing filter's 16-bit input, and the source end of the sensor-to-filter path.

Parameters:
- CLK_DIV, 25, clk cycles per SCLK half-period (50 MHz clk -> 1 MHz SCLK); minimum 2.
- SAMPLE_PERIOD, 500000, clk cycles between read triggers (100 Hz at 50 MHz); must exceed 60*2*CLK_DIV.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- en  in  1  high = periodic reads permitted
- miso  in  1  SPI data from sensor
- sclk  out  1  SPI clock, idle high
- cs_n  out  1  SPI chip select, active low
- mosi  out  1  SPI data to sensor
- x_out  out  16  latest X sample, two's complement
- y_out  out  16  latest Y sample
- z_out  out  16  latest Z sample
- sample_valid  out  1  one-cycle pulse when x/y/z update
- init_done  out  1  high once configuration writes complete

Behaviour:
- Reset (reset==0 at a clk edge): cs_n=1, sclk=1, mosi=0, x/y/z_out=0, sample_valid=0, init_done=0, period counter=0, state=CFG_POWER.
  - Applies mid-transaction: the frame is abandoned and configuration restarts after reset release.
- SPI mode 3, MSB first.
  - Frame start: cs_n falls; CLK_DIV cycles later sclk falls and mosi takes the next bit.
  - CLK_DIV cycles after that, sclk rises and miso is sampled on that same clk edge.
  - Repeat for every bit.
  - After the last rising edge, hold CLK_DIV cycles, then cs_n rises.
  - cs_n stays high at least 2*CLK_DIV cycles before the next frame.
- Command byte: bit7 = R/W (1 = read), bit6 = MB, bits5:0 = address.
- States:
  - CFG_POWER: 16-bit frame 0x2D,0x08 (measure mode) -> CFG_FMT.
  - CFG_FMT: 16-bit frame 0x31,0x0B (full-res, +/-16 g) -> WAIT; init_done=1 from the cycle cs_n rises.
  - WAIT: on period tick with en==1 -> READ. A tick with en==0 is discarded.
  - READ: 56-bit frame. Command 0xF2 (read, multibyte, addr 0x32), then 6 received bytes X0,X1,Y0,Y1,Z0,Z1. mosi=0 during data bytes. -> DONE.
  - DONE: one cycle. x_out={X1,X0}, y_out={Y1,Y0}, z_out={Z1,Z0} all update together; sample_valid=1 for this cycle only -> WAIT.
- Outputs hold their value between DONE cycles.
- Bytes received during configuration frames are ignored.
- Period counter:
  - Free-running from reset release: 0..SAMPLE_PERIOD-1.
  - Tick is asserted when the count is SAMPLE_PERIOD-1.
  - A tick occurring outside WAIT is dropped, never queued.
- en falling during READ: the frame completes and the sample is delivered; no further reads start.
- Latency: tick-to-sample_valid = 1 + (2*56+1)*CLK_DIV + 1 clk cycles, fixed.

Test Plan:
- CLK_DIV=2, SAMPLE_PERIOD=400, release reset with en=1 -> mosi shows 0x2D08, then 0x310B, each under its own cs_n low window with exactly 16 sclk falling edges; init_done rises after the second frame.
- Sensor model returns 0x0C,0xFE,0x32,0x00,0x00,0x01 -> x_out=0xFE0C, y_out=0x0032, z_out=0x0100, a single-cycle sample_valid, 56 sclk rising edges, first mosi byte 0xF2.
- Free run for 5 periods with the model incrementing X by 50 per read -> exactly 5 sample_valid pulses spaced 400 cycles apart; x_out increases by 0x0032 each pulse.
- en=0 held for 3 periods -> cs_n stays high and there is no sample_valid. en raised -> a read starts on the next tick only.
- reset asserted at bit 20 of a READ frame -> cs_n=1, sclk=1 on the next edge and all outputs zero. After release, the 0x2D08 frame is the first activity.
- Check edge spacing throughout -> every sclk high/low phase is exactly CLK_DIV cycles, and mosi never changes while sclk is high.
